regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//   Shares the register file's single write port between NUM_REQ write-back requesters.
//   Requesters include the ALU, the load unit and the CSR/move path.
//   - Round-robin arbitration with per-requester valid/ready handshake.
//   - Registered write stage that drives regfile_write_enable/write_addr/write_data.
//   - Sits between the execute/write-back units and the 8x4-bit register file (R0 hardwired 0).
// PARAMETERS
//   NUM_REQ  4  number of write-back requesters (2..8)
//   CNT_W    8  width of the saturating R0-drop counter
// PORTS
//   clk                   in   1            clock; all state updates on posedge
//   reset                 in   1            synchronous, active-high reset
//   arb_enable            in   1            0: issue no new grants (in-flight write still completes)
//   req_valid             in   NUM_REQ      requester i has a write pending
//   req_addr              in   NUM_REQ*3    dest reg of requester i, bits [3i+2:3i]
//   req_data              in   NUM_REQ*4    write data of requester i, bits [4i+3:4i]
//   req_ready             out  NUM_REQ      one-hot grant; transfer when valid&ready
//   regfile_write_enable  out  1            to register file write port
//   write_addr            out  3            to register file write port
//   write_data            out  4            to register file write port
//   busy_mask             out  8            bit n=1: write to Rn in write stage this cycle
//   r0_drop_cnt           out  CNT_W        saturating count of accepted writes to R0
//   read_addr1/2          in   3            [REGFILE_WB_BYPASS_EN only] read port addresses
//   rf_read_data1/2       in   4            [REGFILE_WB_BYPASS_EN only] raw regfile read data
//   fwd_data1/2           out  4            [REGFILE_WB_BYPASS_EN only] forwarded read data
// BEHAVIOUR
//   - Reset (sync, highest priority):
//     - All outputs 0; write-stage valid 0; busy_mask 0; r0_drop_cnt 0.
//     - RR pointer = 0, so requester 0 has highest priority.
//   - Arbitration (combinational):
//     - When arb_enable=1, grant the first i with req_valid[i]=1, scanning from ptr upward
//       modulo NUM_REQ.
//     - req_ready is one-hot or 0.
//     - req_ready=0 for all requesters while arb_enable=0 or reset=1.
//     - req_ready depends on req_valid only; a requester never sees ready without valid.
//   - Handshake:
//     - Requester holds valid, addr and data stable until valid&ready.
//     - Exactly one transfer per cycle maximum.
//     - Dropping valid without ready is legal and loses nothing.
//   - Pointer: on a transfer by i, ptr <= (i+1) mod NUM_REQ. With no transfer, ptr holds.
//   - Write stage:
//     - A transfer in cycle N loads the stage.
//     - In cycle N+1, regfile_write_enable=1 with the captured addr/data; data is in the
//       regfile at the end of N+1.
//     - Latency request->regfile = 1 cycle.
//     - Throughput: 1 write per cycle.
//     - Stage valid clears in the cycle after the last transfer.
//   - R0:
//     - A request to addr 0 is granted normally (ready=1) and consumes its RR turn.
//     - The write stage then holds regfile_write_enable=0 for that slot.
//     - r0_drop_cnt increments, saturating at 2^CNT_W-1.
//   - busy_mask = onehot(write_addr) when regfile_write_enable=1, else 0. Bit 0 is never set.
//   - Simultaneous events:
//     - Multiple valid requests to the same register are serialized by RR order.
//     - The later grant wins the final value.
//     - A reset in the same cycle as a transfer discards the transfer and the stage contents.
//   - arb_enable falling mid-stream: the already-captured write still issues next cycle.
//     No new grants until arb_enable=1.
// CONFIGURATION
//   REGFILE_WB_BYPASS_EN
//     - Defined: bypass ports exist. For k in {1,2}:
//         fwd_data_k = (regfile_write_enable && read_addr_k==write_addr) ? write_data
//                                                                        : rf_read_data_k
//     - Combinational; read_addr_k==0 always yields 0.
//     - Covers the same-cycle write/read hazard.
//   - Undefined: bypass ports absent. Consumers read the regfile directly and must wait
//     one cycle after regfile_write_enable.
// STRUCTURE
//   - Package regfile_pkg:
//     - REG_ADDR_W=3, REG_DATA_W=4, NUM_REGS=8, REG_ZERO=3'd0.
//     - Type wb_req_t {addr, data}.
//   - Sub-module rr_arbiter:
//     - Params N.
//     - Ports clk, reset, enable, req[N], grant[N], advance.
//     - Owns the pointer.
//   - Top: request mux, write-stage registers, busy_mask decode, drop counter, optional bypass.
// TESTING
//   - Reset: hold reset 2 cycles with all req_valid=1 ->
//     req_ready=0, regfile_write_enable=0, busy_mask=0, r0_drop_cnt=0.
//   - Single request: req0 addr=3 data=0xA ->
//     ready0 same cycle; next cycle we=1, write_addr=3, write_data=0xA, busy_mask=0x08.
//   - Round-robin: all 4 valid continuously (addrs 1..4) ->
//     grants 0,1,2,3,0,... one per cycle; regfile writes follow 1 cycle behind.
//   - R0 drop: req2 addr=0 data=0xF ->
//     ready2=1, next cycle we=0, busy_mask=0, r0_drop_cnt=1.
//     300 such requests -> cnt=255 (saturated).
//   - arb_enable toggle: transfer in cycle N, arb_enable=0 in N+1 ->
//     write issues in N+1; no ready until arb_enable=1; ptr unchanged.
//   - Bypass (macro on): grant addr=5 data=0x6 in N; read_addr1=5 with rf_read_data1=0x2 in N+1 ->
//     fwd_data1=0x6. Same stimulus with macro off -> build without fwd ports.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file definitions for the write-back path: address/data widths,
// the hardwired-zero register and the captured write-back request type.
package regfile_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int REG_DATA_W = 4;
    localparam int NUM_REGS   = 8;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 3'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
        logic [NUM_REGS-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer and
// moves the pointer just past the winner whenever the grant is consumed.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    input  logic         advance
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] grant_idx;
    int               idx;

    // Scan from the farthest offset back to the pointer so the closest hit is kept.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = 0;
        if (enable) begin
            for (int k = N - 1; k >= 0; k--) begin
                idx = int'(ptr) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (req[idx]) begin
                    grant      = '0;
                    grant[idx] = 1'b1;
                    grant_idx  = PTR_W'(idx);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between NUM_REQ write-back requesters.
// Define REGFILE_WB_BYPASS_EN to add the same-cycle write/read forwarding ports.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          arb_enable,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*REG_DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          regfile_write_enable,
    output logic [REG_ADDR_W-1:0]         write_addr,
    output logic [REG_DATA_W-1:0]         write_data,
    output logic [NUM_REGS-1:0]           busy_mask,
`ifdef REGFILE_WB_BYPASS_EN
    input  logic [REG_ADDR_W-1:0]         read_addr1,
    input  logic [REG_ADDR_W-1:0]         read_addr2,
    input  logic [REG_DATA_W-1:0]         rf_read_data1,
    input  logic [REG_DATA_W-1:0]         rf_read_data2,
    output logic [REG_DATA_W-1:0]         fwd_data1,
    output logic [REG_DATA_W-1:0]         fwd_data2,
`endif
    output logic [CNT_W-1:0]              r0_drop_cnt
);

    logic [NUM_REQ-1:0] grant;
    logic               transfer;
    logic               sel_is_r0;
    wb_req_t            sel_req;

    // Grants only go to valid requesters, so any grant is a completed transfer.
    rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
        .clk    (clk),
        .reset  (reset),
        .enable (arb_enable & ~reset),
        .req    (req_valid),
        .grant  (grant),
        .advance(transfer)
    );

    assign req_ready = grant;
    assign transfer  = |grant;
    assign sel_is_r0 = (sel_req.addr == REG_ZERO);

    always_comb begin
        sel_req = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_req.addr = req_addr[REG_ADDR_W*i +: REG_ADDR_W];
                sel_req.data = req_data[REG_DATA_W*i +: REG_DATA_W];
            end
        end
    end

    // An R0 write still takes the slot but never reaches the port; it is only counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            regfile_write_enable <= 1'b0;
            write_addr           <= '0;
            write_data           <= '0;
            busy_mask            <= '0;
            r0_drop_cnt          <= '0;
        end else begin
            regfile_write_enable <= transfer && !sel_is_r0;
            busy_mask            <= (transfer && !sel_is_r0) ? reg_onehot(sel_req.addr) : '0;
            if (transfer) begin
                write_addr <= sel_req.addr;
                write_data <= sel_req.data;
            end
            if (transfer && sel_is_r0 && (r0_drop_cnt != '1)) begin
                r0_drop_cnt <= r0_drop_cnt + 1'b1;
            end
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    assign fwd_data1 = (read_addr1 == REG_ZERO) ? '0 :
                       (regfile_write_enable && read_addr1 == write_addr) ? write_data : rf_read_data1;
    assign fwd_data2 = (read_addr2 == REG_ZERO) ? '0 :
                       (regfile_write_enable && read_addr2 == write_addr) ? write_data : rf_read_data2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_regfile_wb_arbiter;

    localparam int NUM_REQ = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   arb_enable;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*3-1:0]   req_addr;
    logic [NUM_REQ*4-1:0]   req_data;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   regfile_write_enable;
    logic [2:0]             write_addr;
    logic [3:0]             write_data;
    logic [7:0]             busy_mask;
    logic [CNT_W-1:0]       r0_drop_cnt;
`ifdef REGFILE_WB_BYPASS_EN
    logic [2:0]             read_addr1, read_addr2;
    logic [3:0]             rf_read_data1, rf_read_data2, fwd_data1, fwd_data2;
`endif

    int tests = 0;
    int failures = 0;

    // Model state: what the outputs must be after the most recent clock edge.
    int m_ptr = 0, m_addr = 0, m_data = 0, m_cnt = 0, m_last_grant = -1;
    bit m_we = 0, m_known = 0;
    int n_ptr, n_addr, n_data, n_cnt, n_last_grant;
    bit n_we, n_known;

    regfile_wb_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
        .clk                 (clk),
        .reset               (reset),
        .arb_enable          (arb_enable),
        .req_valid           (req_valid),
        .req_addr            (req_addr),
        .req_data            (req_data),
        .req_ready           (req_ready),
        .regfile_write_enable(regfile_write_enable),
        .write_addr          (write_addr),
        .write_data          (write_data),
        .busy_mask           (busy_mask),
`ifdef REGFILE_WB_BYPASS_EN
        .read_addr1          (read_addr1),
        .read_addr2          (read_addr2),
        .rf_read_data1       (rf_read_data1),
        .rf_read_data2       (rf_read_data2),
        .fwd_data1           (fwd_data1),
        .fwd_data2           (fwd_data2),
`endif
        .r0_drop_cnt         (r0_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int modelGrant();
        int i;
        if (reset || !arb_enable) return -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            i = (m_ptr + k) % NUM_REQ;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic setReq(input int i, input bit v, input int a, input int d);
        req_valid[i]      = v;
        req_addr[3*i +: 3] = 3'(a);
        req_data[4*i +: 4] = 4'(d);
    endtask

    // Per-cycle comparison of every meaningful output against the model.
    task automatic checkOutput();
        int g;
        logic [NUM_REQ-1:0] exp_ready;
        if (!m_known) return;
        g = modelGrant();
        exp_ready = (g < 0) ? '0 : NUM_REQ'(1 << g);
        compareVal("model req_ready", 32'(req_ready), 32'(exp_ready));
        compareVal("model write_enable", 32'(regfile_write_enable), 32'(m_we));
        if (m_we) begin
            compareVal("model write_addr", 32'(write_addr), 32'(m_addr));
            compareVal("model write_data", 32'(write_data), 32'(m_data));
        end
        compareVal("model busy_mask", 32'(busy_mask), m_we ? (32'd1 << m_addr) : 32'd0);
        compareVal("model r0_drop_cnt", 32'(r0_drop_cnt), 32'(m_cnt));
`ifdef REGFILE_WB_BYPASS_EN
        compareVal("model fwd_data1", 32'(fwd_data1), (read_addr1 == 0) ? 32'd0 :
                   (m_we && read_addr1 == m_addr) ? 32'(m_data) : 32'(rf_read_data1));
        compareVal("model fwd_data2", 32'(fwd_data2), (read_addr2 == 0) ? 32'd0 :
                   (m_we && read_addr2 == m_addr) ? 32'(m_data) : 32'(rf_read_data2));
`endif
    endtask

    task automatic modelNext();
        int g, a;
        g = modelGrant();
        n_ptr = m_ptr; n_addr = m_addr; n_data = m_data; n_cnt = m_cnt;
        n_we = 0; n_last_grant = g; n_known = m_known || reset;
        if (reset) begin
            n_ptr = 0; n_addr = 0; n_data = 0; n_cnt = 0;
        end else if (g >= 0) begin
            a      = int'(req_addr[3*g +: 3]);
            n_ptr  = (g + 1) % NUM_REQ;
            n_we   = (a != 0);
            n_addr = a;
            n_data = int'(req_data[4*g +: 4]);
            if (a == 0 && m_cnt < CNT_MAX) n_cnt = m_cnt + 1;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        checkOutput();
        modelNext();
        @(posedge clk);
        #1;
        m_ptr = n_ptr; m_addr = n_addr; m_data = n_data; m_cnt = n_cnt;
        m_we = n_we; m_known = n_known; m_last_grant = n_last_grant;
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!(req_valid[i] && m_last_grant != i && $urandom_range(0, 9) < 8)) begin
                setReq(i, $urandom_range(0, 2) != 0,
                       ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 15)));
            end
        end
        arb_enable = $urandom_range(0, 9) != 0;
        reset      = $urandom_range(0, 99) == 0;
`ifdef REGFILE_WB_BYPASS_EN
        read_addr1    = 3'($urandom_range(0, 7));
        read_addr2    = (m_we && $urandom_range(0, 1) == 0) ? 3'(m_addr) : 3'($urandom_range(0, 7));
        rf_read_data1 = 4'($urandom_range(0, 15));
        rf_read_data2 = 4'($urandom_range(0, 15));
`endif
    endtask

    task automatic resetOneCycle();
        reset = 1'b1; req_valid = '0;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; arb_enable = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
`ifdef REGFILE_WB_BYPASS_EN
        read_addr1 = '0; read_addr2 = '0; rf_read_data1 = '0; rf_read_data2 = '0;
`endif
        // Reset held two cycles with every requester valid.
        for (int i = 0; i < NUM_REQ; i++) setReq(i, 1, i + 1, i + 8);
        #1;
        compareVal("reset ready", 32'(req_ready), 32'h0);
        cycle();
        compareVal("reset ready 2", 32'(req_ready), 32'h0);
        cycle();
        compareVal("reset we", 32'(regfile_write_enable), 32'h0);
        compareVal("reset busy", 32'(busy_mask), 32'h0);
        compareVal("reset cnt", 32'(r0_drop_cnt), 32'h0);

        // Single request: R3 <= 0xA.
        reset = 1'b0; req_valid = '0;
        setReq(0, 1, 3, 'hA);
        #1;
        compareVal("single ready", 32'(req_ready), 32'h1);
        cycle();
        req_valid = '0;
        #1;
        compareVal("single we", 32'(regfile_write_enable), 32'h1);
        compareVal("single addr", 32'(write_addr), 32'h3);
        compareVal("single data", 32'(write_data), 32'hA);
        compareVal("single busy", 32'(busy_mask), 32'h08);
        cycle();

        // Round-robin from a fresh pointer: grants 0,1,2,3,0,1.
        resetOneCycle();
        for (int i = 0; i < NUM_REQ; i++) setReq(i, 1, i + 1, i + 4);
        for (int c = 0; c < 6; c++) begin
            #1;
            compareVal("rr grant", 32'(req_ready), 32'h1 << (c % 4));
            if (c > 0) begin
                compareVal("rr write addr", 32'(write_addr), 32'((c - 1) % 4 + 1));
                compareVal("rr we", 32'(regfile_write_enable), 32'h1);
            end
            cycle();
        end

        // R0 drop and counter saturation.
        resetOneCycle();
        setReq(2, 1, 0, 'hF);
        #1;
        compareVal("r0 ready", 32'(req_ready), 32'h4);
        cycle();
        req_valid = '0;
        #1;
        compareVal("r0 we", 32'(regfile_write_enable), 32'h0);
        compareVal("r0 busy", 32'(busy_mask), 32'h0);
        compareVal("r0 cnt", 32'(r0_drop_cnt), 32'h1);
        req_valid[2] = 1'b1;
        for (int c = 0; c < 299; c++) cycle();
        req_valid = '0;
        #1;
        compareVal("r0 cnt saturated", 32'(r0_drop_cnt), 32'd255);
        cycle();

        // arb_enable drops right after a transfer.
        resetOneCycle();
        setReq(1, 1, 6, 9);
        #1;
        compareVal("en ready", 32'(req_ready), 32'h2);
        cycle();
        arb_enable = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) setReq(i, 1, i + 1, i);
        #1;
        compareVal("en off ready", 32'(req_ready), 32'h0);
        compareVal("en off we", 32'(regfile_write_enable), 32'h1);
        compareVal("en off addr", 32'(write_addr), 32'h6);
        cycle();
        #1;
        compareVal("en off ready 2", 32'(req_ready), 32'h0);
        compareVal("en off we 2", 32'(regfile_write_enable), 32'h0);
        cycle();
        arb_enable = 1'b1;
        #1;
        compareVal("en on ptr kept", 32'(req_ready), 32'h4);
        cycle();

`ifdef REGFILE_WB_BYPASS_EN
        // Same-cycle forwarding of R5 <= 0x6.
        resetOneCycle();
        setReq(0, 1, 5, 6);
        cycle();
        req_valid = '0;
        read_addr1 = 3'd5; rf_read_data1 = 4'h2;
        read_addr2 = 3'd0; rf_read_data2 = 4'h7;
        #1;
        compareVal("bypass fwd1", 32'(fwd_data1), 32'h6);
        compareVal("bypass fwd2 r0", 32'(fwd_data2), 32'h0);
        cycle();
`endif

        // Randomized traffic, including sporadic resets and enable gaps.
        resetOneCycle();
        for (int c = 0; c < 3000; c++) begin
            applyStimulus();
            cycle();
        end
        reset = 1'b0; req_valid = '0;
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
